johnson_seq_ctrl: RTL and testbench

JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

---
 rtl/johnson_seq_ctrl_if.sv | 35 +++
 rtl/johnson_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// Control/status bundle for the Johnson sequence controller.
// The master side drives run control and load; the slave side reports the register and flags.
interface johnson_seq_ctrl_if #(
  parameter int N    = 4,
  parameter int CNTW = 8
);
  localparam int PW = $clog2(2 * N);

  logic            start;
  logic            stop;
  logic            pause;
  logic            mode;
  logic [CNTW-1:0] step_count;
  logic            load;
  logic [N-1:0]    load_val;
  logic            err_clr;

  logic [N-1:0]    q;
  logic [PW-1:0]   phase;
  logic            phase_valid;
  logic            busy;
  logic            done;
  logic            wrap;
  logic            err;

  modport master (
    output start, stop, pause, mode, step_count, load, load_val, err_clr,
    input  q, phase, phase_valid, busy, done, wrap, err
  );

  modport slave (
    input  start, stop, pause, mode, step_count, load, load_val, err_clr,
    output q, phase, phase_valid, busy, done, wrap, err
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Johnson-counter sequencer: one-shot or continuous runs with pause/stop,
// parallel load in IDLE, phase decode and a sticky illegal-code flag.
module johnson_seq_ctrl #(
  parameter int N    = 4,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  johnson_seq_ctrl_if.slave bus
);
  localparam int PW = $clog2(2 * N);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    q_r;
  logic [CNTW-1:0] remaining;
  logic            mode_r;
  logic            done_r;
  logic            wrap_r;
  logic            err_r;

  logic            do_load;
  logic            do_start;
  logic            zero_done;
  logic            do_adv;
  logic            last;
  logic            err_set;
  logic [PW:0]     q_dec;
  logic [PW:0]     ld_dec;
  logic [N-1:0]    adv_q;

  // Walk the 2N legal codes; anything unmatched decodes to {invalid, phase 0}.
  function automatic logic [PW:0] decode(input logic [N-1:0] v);
    logic [N-1:0] code;
    logic [PW:0]  res;
    code = '0;
    res  = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (v == code) res = {1'b1, PW'(k)};
      code = {code[N-2:0], ~code[N-1]};
    end
    return res;
  endfunction

  function automatic logic [N-1:0] advance(input logic [N-1:0] v);
    return {v[N-2:0], ~v[N-1]};
  endfunction

  assign q_dec  = decode(q_r);
  assign ld_dec = decode(bus.load_val);
  // An illegal code recovers to zero instead of propagating garbage.
  assign adv_q  = q_dec[PW] ? advance(q_r) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_start) state_nxt = RUN;
      RUN:     if (bus.stop || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_load   = 1'b0;
    do_start  = 1'b0;
    zero_done = 1'b0;
    do_adv    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.stop) begin
          if (bus.load) begin
            do_load = 1'b1;
          end else if (bus.start) begin
            if (bus.mode || bus.step_count != '0) do_start  = 1'b1;
            else                                  zero_done = 1'b1;
          end
        end
      end
      RUN: begin
        if (!bus.stop && !bus.pause) begin
          do_adv = 1'b1;
          last   = !mode_r && (remaining == CNTW'(1));
        end
      end
      default: ;
    endcase
  end

  assign err_set = (do_load && !ld_dec[PW]) || (do_adv && !q_dec[PW]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r       <= '0;
      remaining <= '0;
      mode_r    <= 1'b0;
      done_r    <= 1'b0;
      wrap_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= zero_done || last;
      wrap_r <= do_adv && (adv_q == '0);
      err_r  <= err_set || (err_r && !bus.err_clr);
      if (do_load)     q_r <= bus.load_val;
      else if (do_adv) q_r <= adv_q;
      if (do_start) begin
        remaining <= bus.step_count;
        mode_r    <= bus.mode;
      end else if (do_adv && !mode_r) begin
        remaining <= remaining - CNTW'(1);
      end
    end
  end

  assign bus.q           = q_r;
  assign bus.phase       = q_dec[PW-1:0];
  assign bus.phase_valid = q_dec[PW];
  assign bus.busy        = (state == RUN);
  assign bus.done        = done_r;
  assign bus.wrap        = wrap_r;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl with a cycle-level reference model feeding
// an expected-value queue, plus explicit checks of the headline scenarios.
module tb_johnson_seq_ctrl;
  localparam int N    = 4;
  localparam int CNTW = 8;
  localparam int PW   = $clog2(2 * N);
  localparam int EW   = N + PW + 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  johnson_seq_ctrl_if #(.N(N), .CNTW(CNTW)) bus ();

  johnson_seq_ctrl #(.N(N), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0]   sb[$];
  logic            m_run;
  logic [N-1:0]    m_q;
  logic [CNTW-1:0] m_rem;
  logic            m_mode;
  logic            m_done;
  logic            m_wrap;
  logic            m_err;

  // Popcount-based legality: ones packed at the LSB end, or at the MSB end.
  function automatic logic [PW:0] m_decode(input logic [N-1:0] v);
    int pc;
    pc = $countones(v);
    if (!v[N-1]) return (v == N'((1 << pc) - 1)) ? {1'b1, PW'(pc)} : '0;
    if (v == ~N'((1 << (N - pc)) - 1)) return {1'b1, PW'(2 * N - pc)};
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic         eset;
    logic [N-1:0] nq;
    logic [PW:0]  d;
    eset = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_q = '0; m_rem = '0; m_mode = 0; m_done = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_wrap = 0;
      if (!m_run) begin
        if (!bus.stop) begin
          if (bus.load) begin
            m_q  = bus.load_val;
            d    = m_decode(bus.load_val);
            eset = !d[PW];
          end else if (bus.start) begin
            if (!bus.mode && bus.step_count == '0) begin
              m_done = 1;
            end else begin
              m_run  = 1;
              m_rem  = bus.step_count;
              m_mode = bus.mode;
            end
          end
        end
      end else if (bus.stop) begin
        m_run = 0;
      end else if (!bus.pause) begin
        d = m_decode(m_q);
        if (!d[PW]) begin
          nq   = '0;
          eset = 1'b1;
        end else begin
          nq = {m_q[N-2:0], ~m_q[N-1]};
        end
        m_q    = nq;
        m_wrap = (nq == '0);
        if (!m_mode) begin
          if (m_rem == CNTW'(1)) begin
            m_run  = 0;
            m_done = 1;
          end
          m_rem = m_rem - CNTW'(1);
        end
      end
      m_err = eset || (m_err && !bus.err_clr);
    end
    d = m_decode(m_q);
    sb.push_back({m_q, d[PW-1:0], d[PW], m_run, m_done, m_wrap, m_err});
  endtask

  // Predict this edge, let the DUT take it, then compare away from the edge.
  task automatic cyc(input string tag);
    logic [EW-1:0] exp;
    logic [EW-1:0] obs;
    model_step();
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    obs = {bus.q, bus.phase, bus.phase_valid, bus.busy, bus.done, bus.wrap, bus.err};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic idle_in();
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.mode = 0;
    bus.step_count = '0; bus.load = 0; bus.load_val = '0; bus.err_clr = 0;
  endtask

  int           wraps;
  int           busy_cnt;
  logic [N-1:0] qh;

  initial begin
    checks = 0;
    errors = 0;
    idle_in();
    rst_n = 0;
    cyc("reset0");
    cyc("reset1");
    chk("rst_q", 32'(bus.q), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_phase", 32'({bus.phase_valid, bus.phase}), 32'({1'b1, 3'd0}));
    rst_n = 1;
    cyc("idle");

    // one-shot, three steps; step_count changed mid-run must be ignored
    bus.start = 1; bus.step_count = 8'd3;
    cyc("os3_start");
    chk("os3_q_held", 32'(bus.q), 32'(4'b0000));
    bus.start = 0; bus.step_count = 8'd9;
    cyc("os3_a1");
    chk("os3_q1", 32'(bus.q), 32'(4'b0001));
    cyc("os3_a2");
    chk("os3_q2", 32'(bus.q), 32'(4'b0011));
    cyc("os3_a3");
    chk("os3_done", 32'({bus.q, bus.done, bus.phase}), 32'({4'b0111, 1'b1, 3'd3}));
    cyc("os3_after");
    chk("os3_idle", 32'({bus.busy, bus.done}), 32'(0));

    // continuous from zero; load/start while busy are ignored
    idle_in(); bus.load = 1; bus.load_val = 4'b0000;
    cyc("ld0");
    idle_in(); bus.start = 1; bus.mode = 1; bus.step_count = 8'd1;
    cyc("cont_start");
    idle_in();
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      cyc("cont_adv");
      if (bus.wrap) wraps++;
    end
    chk("cont_wraps", 32'(wraps), 32'(1));
    chk("cont_q0", 32'(bus.q), 32'(4'b0000));
    bus.load = 1; bus.load_val = 4'b1111; bus.start = 1;
    cyc("cont_ign1");
    cyc("cont_ign2");
    chk("cont_busy", 32'({bus.busy, bus.q}), 32'({1'b1, 4'b0011}));
    idle_in(); bus.stop = 1;
    qh = bus.q;
    cyc("cont_stop");
    chk("stop_busy", 32'({bus.busy, bus.done}), 32'(0));
    chk("stop_q", 32'(bus.q), 32'(qh));
    idle_in();
    cyc("stop_hold");
    chk("stop_q2", 32'(bus.q), 32'(qh));

    // one-shot five steps with a two-cycle pause after the second advance
    bus.load = 1; bus.load_val = 4'b0000;
    cyc("ld0b");
    idle_in(); bus.start = 1; bus.step_count = 8'd5;
    busy_cnt = 0;
    cyc("p_start");
    if (bus.busy) busy_cnt++;
    idle_in();
    for (int i = 0; i < 2; i++) begin
      cyc("p_adv");
      if (bus.busy) busy_cnt++;
    end
    bus.pause = 1;
    for (int i = 0; i < 2; i++) begin
      cyc("p_pause");
      if (bus.busy) busy_cnt++;
      chk("p_frozen", 32'({bus.q, bus.wrap, bus.done}), 32'({4'b0011, 2'b00}));
    end
    bus.pause = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("p_adv2");
      if (bus.busy) busy_cnt++;
    end
    chk("p_done", 32'({bus.q, bus.done, bus.phase}), 32'({4'b1110, 1'b1, 3'd5}));
    for (int i = 0; i < 3; i++) begin
      cyc("p_tail");
      if (bus.busy) busy_cnt++;
    end
    chk("p_busy_cnt", 32'(busy_cnt), 32'(7));

    // illegal load, recovery advance, err_clr
    bus.load = 1; bus.load_val = 4'b0101;
    cyc("ill_ld");
    chk("ill_flags", 32'({bus.err, bus.phase_valid, bus.phase}), 32'({1'b1, 1'b0, 3'd0}));
    idle_in(); bus.start = 1; bus.step_count = 8'd1;
    cyc("ill_start");
    idle_in();
    cyc("ill_adv");
    chk("ill_rec", 32'({bus.q, bus.wrap, bus.done, bus.err}), 32'({4'b0000, 3'b111}));
    bus.err_clr = 1;
    cyc("errclr");
    chk("errclr_err", 32'(bus.err), 32'(0));
    bus.load = 1; bus.load_val = 4'b1010;
    cyc("errclr_new");
    chk("errclr_keep", 32'(bus.err), 32'(1));
    idle_in(); bus.err_clr = 1;
    cyc("errclr2");

    // start with zero steps: done only
    idle_in(); bus.start = 1; bus.step_count = 8'd0;
    cyc("zero_start");
    chk("zero_done", 32'({bus.done, bus.busy}), 32'(2'b10));
    idle_in();
    cyc("zero_after");
    chk("zero_clear", 32'({bus.done, bus.busy}), 32'(0));

    // stop+start in IDLE, then load+start together
    qh = bus.q;
    bus.stop = 1; bus.start = 1; bus.step_count = 8'd2;
    cyc("stopstart");
    chk("stopstart_q", 32'({bus.busy, bus.q}), 32'({1'b0, qh}));
    idle_in(); bus.load = 1; bus.load_val = 4'b0011; bus.start = 1; bus.step_count = 8'd2;
    cyc("ldstart");
    chk("ldstart_q", 32'({bus.busy, bus.q}), 32'({1'b0, 4'b0011}));

    // reset in the middle of a run with err set
    idle_in(); bus.load = 1; bus.load_val = 4'b1001;
    cyc("mr_ill");
    idle_in(); bus.start = 1; bus.step_count = 8'd4;
    cyc("mr_start");
    idle_in();
    cyc("mr_adv");
    chk("mr_busy", 32'(bus.busy), 32'(1));
    rst_n = 0;
    cyc("mr_rst");
    chk("mr_vals", 32'({bus.q, bus.phase, bus.phase_valid, bus.busy, bus.done, bus.wrap, bus.err}),
        32'({4'b0000, 3'd0, 1'b1, 4'b0000}));
    rst_n = 1;
    cyc("mr_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
